fetch_decode_stage: RTL
=======================

Name: fetch_decode_stage

Overview:
Front end of the RV32I 5-stage pipeline, covering the F and D stages. It owns the PC, drives the synchronous-read instruction memory and holds the IF/ID register. It produces the 24-bit packed decode bundle (D_out) and the decoded immediate that the pipeline controller and datapath consume. It obeys the controller's stall and next_pc_sel redirect, inserting NOP bubbles where required.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  load-use stall from controller; hold F and D
next_pc_sel  in  1  1 = sequential PC+4; 0 = redirect to jb_target (jal/jalr/taken branch in E)
jb_target  in  32  redirect target from E-stage jump/branch adder
im_addr  out  32  instruction memory address, equal to F_pc
im_rdata  in  32  instruction memory data; synchronous read, valid one cycle after im_addr
D_pc  out  32  PC of the instruction in D
D_inst  out  32  instruction in D (NOP_INST when invalid)
D_valid  out  1  D holds a real (non-bubble) instruction
D_out  out  24  packed fields: [4:0]=inst[6:2], [9:5]=rd, [12:10]=f3, [17:13]=rs1, [22:18]=rs2, [23]=inst[30]
D_imm  out  32  sign-extended immediate of D_inst

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - F_pc <= RESET_PC; D_pc <= 0; D_valid <= 0; hold_valid <= 0; hold_inst <= NOP_INST.
  - Outputs during and after reset until the first fetch returns: D_inst=NOP_INST, D_out=24'h000004, D_imm=0.
  - rst overrides stall and redirect in the same cycle.
- State: F_pc, D_pc, D_valid, hold_valid, hold_inst. Modes: RUN (hold_valid=0) and HOLD (hold_valid=1).
- D_inst = !D_valid ? NOP_INST : (hold_valid ? hold_inst : im_rdata).
- Per-edge priority is rst > redirect (next_pc_sel=0) > stall > advance.
  - Redirect:
    - F_pc <= {jb_target[31:1],1'b0}.
    - D_valid <= 0, because the next im_rdata is the wrong-path fetch.
    - hold_valid <= 0.
    - D_pc is don't-care.
    - Redirect wins over a simultaneous stall.
  - Stall:
    - F_pc and D_pc hold; D_valid holds.
    - If hold_valid=0: hold_inst <= D_inst, hold_valid <= 1 (RUN->HOLD). This is needed because im_rdata moves on to mem[F_pc].
    - If hold_valid=1: stay in HOLD, hold_inst unchanged.
  - Advance:
    - F_pc <= F_pc+4 (wraps modulo 2^32).
    - D_pc <= F_pc; D_valid <= 1; hold_valid <= 0 (HOLD->RUN).
- Latency:
  - Instruction at address A appears in D one cycle after im_addr=A is presented.
  - A redirect gives exactly one bubble cycle in D; the target appears in D two edges after the redirect edge.
- Stall releasing: the held instruction stays visible for the release cycle, then the next sequential instruction follows with no gap and no duplicate.
- Decode (combinational from D_inst):
  - D_out per the field map above.
  - D_imm by opcode[6:2]:
    - 00100/00000/11001 (I type): {{20{i[31]}},i[31:20]}
    - 01000 (S type): {{20{i[31]}},i[31:25],i[11:7]}
    - 11000 (B type): {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
    - 01101/00101 (U type): {i[31:12],12'b0}
    - 11011 (J type): {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
    - 01100 and all other opcodes: 0
- No illegal-instruction detection; unknown opcodes pass through undecoded with D_imm=0.

Test Plan:
- Reset then run, with mem[0]=0x00500093, mem[4]=0x123451B7, mem[8]=0x010000EF:
  - im_addr goes 0,4,8,...; D_valid=0 in the first cycle.
  - Next D_pc=0, D_out={0,00101,00000,000,00001,00100}, D_imm=5.
  - Then D_pc=4, D_imm=0x12345000.
  - Then D_pc=8, D_imm=16.
- Stall for 3 cycles while D_pc=4:
  - D_pc=4, D_inst=0x123451B7 and im_addr=8 are held for all 3 cycles plus the release cycle.
  - Then D_pc=8, D_inst=0x010000EF, with no duplicate or skip.
- Redirect next_pc_sel=0, jb_target=0x41 while F_pc=0xC:
  - Next cycle im_addr=0x40, D_valid=0, D_inst=NOP.
  - Following cycle D_pc=0x40, D_valid=1.
- stall=1 and next_pc_sel=0 in the same cycle, jb_target=0x100:
  - Redirect wins: im_addr=0x100, hold_valid cleared, one bubble.
  - D_pc=0x100 two edges after the redirect edge.
- rst asserted mid-HOLD:
  - Next edge F_pc=RESET_PC, D_valid=0, hold_valid=0, D_out=24'h000004.
  - Normal fetch from RESET_PC resumes.
- Branch immediate: D_inst=0xFE208CE3 (beq x1,x2,-8) -> D_imm=0xFFFFFFF8, D_out[17:13]=1, D_out[22:18]=2.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: RV32I fetch/decode front end.
// Owns the PC, IF/ID register, stall hold buffer and immediate/field decode.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        next_pc_sel,
  input  logic [31:0] jb_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic        D_valid,
  output logic [23:0] D_out,
  output logic [31:0] D_imm
);
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        d_valid_q, d_valid_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] inst;
  logic [4:0]  opc;
  logic        unused_bits;

  // im_rdata tracks mem[F_pc], so a stalled D must replay from the hold buffer
  assign inst    = !d_valid_q ? NOP_INST : (hold_valid_q ? hold_inst_q : im_rdata);
  assign opc     = inst[6:2];
  assign im_addr = f_pc_q;
  assign D_pc    = d_pc_q;
  assign D_inst  = inst;
  assign D_valid = d_valid_q;
  assign D_out   = {inst[30], inst[24:20], inst[19:15], inst[14:12], inst[11:7], inst[6:2]};
  assign unused_bits = &{1'b0, inst[1:0], jb_target[0]};

  always_comb begin
    f_pc_d       = f_pc_q;
    d_pc_d       = d_pc_q;
    d_valid_d    = d_valid_q;
    hold_valid_d = hold_valid_q;
    hold_inst_d  = hold_inst_q;
    if (!next_pc_sel) begin
      f_pc_d       = {jb_target[31:1], 1'b0};
      d_valid_d    = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      hold_valid_d = 1'b1;
      hold_inst_d  = hold_valid_q ? hold_inst_q : inst;
    end else begin
      f_pc_d       = f_pc_q + 32'd4;
      d_pc_d       = f_pc_q;
      d_valid_d    = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc_q       <= RESET_PC;
      d_pc_q       <= '0;
      d_valid_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= NOP_INST;
    end else begin
      f_pc_q       <= f_pc_d;
      d_pc_q       <= d_pc_d;
      d_valid_q    <= d_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  always_comb begin
    D_imm = '0;
    case (opc)
      5'b00100, 5'b00000, 5'b11001: D_imm = {{20{inst[31]}}, inst[31:20]};
      5'b01000: D_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      5'b11000: D_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      5'b01101, 5'b00101: D_imm = {inst[31:12], 12'b0};
      5'b11011: D_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: D_imm = '0;
    endcase
  end
endmodule
